// File: rtl/pmem_read_arbiter_if.sv
// Request/response bundle between the fetch unit, the data-load port, the arbiter
// and the program-memory ROM read port.
interface pmem_read_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              f_req_c0;
  logic [ADDR_W-1:0] f_addr_c0;
  logic              f_gnt_c0;
  logic              f_valid_c1;
  logic [DATA_W-1:0] f_data_c1;
  logic              d_req_c0;
  logic [ADDR_W-1:0] d_addr_c0;
  logic              d_gnt_c0;
  logic              d_valid_c1;
  logic [DATA_W-1:0] d_data_c1;
  logic              d_err_c1;
  logic [ADDR_W-1:0] pmem_addr_c0;
  logic [DATA_W-1:0] instr_reg_c1;

  // Requesters plus ROM side
  modport master (
    output f_req_c0, f_addr_c0, d_req_c0, d_addr_c0, instr_reg_c1,
    input  f_gnt_c0, f_valid_c1, f_data_c1,
    input  d_gnt_c0, d_valid_c1, d_data_c1, d_err_c1, pmem_addr_c0
  );

  // Arbiter side
  modport slave (
    input  f_req_c0, f_addr_c0, d_req_c0, d_addr_c0, instr_reg_c1,
    output f_gnt_c0, f_valid_c1, f_data_c1,
    output d_gnt_c0, d_valid_c1, d_data_c1, d_err_c1, pmem_addr_c0
  );
endinterface

// File: rtl/pmem_read_arbiter.sv
// Shares the 1-cycle-latency program ROM read port between instruction fetch and
// data loads; data wins by default, a starvation counter forces periodic fetch wins.
module pmem_read_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  pmem_read_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] f_word_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic              own_f_q;
  logic              own_d_q;
  logic              err_q;
  logic              aligned;
  logic              d_rom_req;
  logic              force_f;
  logic              f_gnt;
  logic              d_rom_gnt;
  logic              d_gnt;

  // Arbitration; grants are gated by rst_n so nothing is issued during reset
  always_comb begin
    aligned     = (bus.d_addr_c0[1:0] == 2'b00);
    d_rom_req   = bus.d_req_c0 & aligned;
    force_f     = (starve_cnt == CNT_W'(STARVE_MAX));
    f_gnt       = rst_n & bus.f_req_c0 & (~d_rom_req | force_f);
    d_rom_gnt   = rst_n & d_rom_req & ~(bus.f_req_c0 & force_f);
    d_gnt       = d_rom_gnt | (rst_n & bus.d_req_c0 & ~aligned);
    f_word_addr = bus.f_addr_c0 & ~ADDR_W'(3);
    rom_addr    = last_addr;
    if (f_gnt) begin
      rom_addr = f_word_addr;
    end else if (d_rom_gnt) begin
      rom_addr = bus.d_addr_c0;
    end
  end

  // Starvation counter, held address and c1 ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      last_addr  <= '0;
      own_f_q    <= 1'b0;
      own_d_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (bus.f_req_c0 && !f_gnt) begin
        starve_cnt <= force_f ? starve_cnt : starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      last_addr <= rom_addr;
      own_f_q   <= f_gnt;
      own_d_q   <= d_gnt & aligned;
      err_q     <= d_gnt & ~aligned;
    end
  end

  assign bus.f_gnt_c0     = f_gnt;
  assign bus.d_gnt_c0     = d_gnt;
  assign bus.pmem_addr_c0 = rom_addr;

  // Steer the ROM word to whichever port owns the read in flight
  assign bus.f_valid_c1 = own_f_q;
  assign bus.f_data_c1  = own_f_q ? bus.instr_reg_c1 : DATA_W'(0);
  assign bus.d_valid_c1 = own_d_q | err_q;
  assign bus.d_data_c1  = own_d_q ? bus.instr_reg_c1 : DATA_W'(0);
  assign bus.d_err_c1   = err_q;

endmodule

// File: tb/tb_pmem_read_arbiter.sv
// Directed and random checks of pmem_read_arbiter against a cycle-level
// behavioural model and a behavioural ROM.
module tb_pmem_read_arbiter;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pmem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pmem_read_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PMEM_2: registered read, word index from address bits [9:2]
  logic [31:0] rom [256];
  always @(posedge clk) bus.instr_reg_c1 <= rom[bus.pmem_addr_c0[9:2]];

  // Reference model state
  int          streak;      // consecutive denied fetch cycles
  logic [9:0]  m_last;
  logic        x_fv, x_dv, x_de;
  logic [31:0] x_fd, x_dd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_c1();
    chk("f_valid", 32'(bus.f_valid_c1), 32'(x_fv));
    chk("f_data",  bus.f_data_c1, x_fd);
    chk("d_valid", 32'(bus.d_valid_c1), 32'(x_dv));
    chk("d_data",  bus.d_data_c1, x_dd);
    chk("d_err",   32'(bus.d_err_c1), 32'(x_de));
  endtask

  // One c0 cycle: drive, check c0 grants and c1 responses, advance the model
  task automatic step(input logic fr, input logic [9:0] fa, input logic dr, input logic [9:0] da);
    logic mis, dwants, fwin, dwin;
    logic [9:0] ea;
    @(negedge clk);
    bus.f_req_c0 = fr; bus.f_addr_c0 = fa;
    bus.d_req_c0 = dr; bus.d_addr_c0 = da;
    #1;
    mis    = dr && (da % 4 != 0);
    dwants = dr && !mis;
    if (fr && dwants) begin
      fwin = (streak == STARVE_MAX);
      dwin = !fwin;
    end else begin
      fwin = fr;
      dwin = dwants;
    end
    ea = fwin ? 10'((fa / 4) * 4) : (dwin ? da : m_last);
    chk("f_gnt", 32'(bus.f_gnt_c0), 32'(fwin));
    chk("d_gnt", 32'(bus.d_gnt_c0), 32'(dwin || mis));
    chk("pmem_addr", 32'(bus.pmem_addr_c0), 32'(ea));
    check_c1();
    streak = (fr && !fwin) ? ((streak < STARVE_MAX) ? streak + 1 : streak) : 0;
    m_last = ea;
    x_fv = fwin;
    x_fd = fwin ? rom[ea / 4] : 32'h0;
    x_dv = dwin || mis;
    x_dd = dwin ? rom[ea / 4] : 32'h0;
    x_de = mis;
  endtask

  task automatic model_reset();
    streak = 0; m_last = '0;
    x_fv = 1'b0; x_dv = 1'b0; x_de = 1'b0; x_fd = '0; x_dd = '0;
  endtask

  // Reset pulse with a pending fetch request; everything must be quiet
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.f_req_c0 = 1'b1; bus.f_addr_c0 = 10'h004;
    bus.d_req_c0 = 1'b0; bus.d_addr_c0 = '0;
    model_reset();
    #1;
    chk("rst_f_gnt", 32'(bus.f_gnt_c0), 32'h0);
    chk("rst_pmem_addr", 32'(bus.pmem_addr_c0), 32'h0);
    check_c1();
    @(negedge clk);
    rst_n = 1'b1;
    bus.f_req_c0 = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0]    = 32'h0000_0113;
    rom[1]    = 32'h0000_0413;
    rom[2]    = 32'h0000_0013;
    rom[8'h1e] = 32'hff01_0113;
    rom[8'h1f] = 32'h1234_5678;
    bus.f_req_c0 = 1'b0; bus.f_addr_c0 = '0;
    bus.d_req_c0 = 1'b0; bus.d_addr_c0 = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset with fetch requested, then idle after release
    pulse_reset();
    step(1'b0, 10'h000, 1'b0, 10'h000);
    step(1'b0, 10'h000, 1'b0, 10'h000);

    // Fetch-only stream, then a fetch with low address bits set
    step(1'b1, 10'h000, 1'b0, 10'h000);
    step(1'b1, 10'h004, 1'b0, 10'h000);
    step(1'b1, 10'h008, 1'b0, 10'h000);
    step(1'b1, 10'h006, 1'b0, 10'h000);
    step(1'b0, 10'h000, 1'b0, 10'h000);
    chk("fixed_f_data_0x004", bus.f_data_c1, 32'h0000_0413);

    // Starvation: data wins 4 cycles, fetch forced on the 5th, data again after
    for (int c = 0; c < 7; c++) step(1'b1, 10'h000, 1'b1, 10'h078);
    step(1'b0, 10'h000, 1'b0, 10'h000);
    chk("fixed_d_data_0x078", bus.d_data_c1, 32'hff01_0113);

    // Misaligned data alongside a fetch
    step(1'b1, 10'h004, 1'b1, 10'h002);
    step(1'b0, 10'h000, 1'b0, 10'h000);
    chk("fixed_mis_f_data", bus.f_data_c1, 32'h0000_0413);

    // Forced fetch coincident with a misaligned request
    for (int c = 0; c < 4; c++) step(1'b1, 10'h010, 1'b1, 10'h078);
    step(1'b1, 10'h010, 1'b1, 10'h079);
    step(1'b1, 10'h010, 1'b1, 10'h078);

    // Idle hold after a data grant at 0x07C
    step(1'b0, 10'h000, 1'b1, 10'h07c);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 10'h000, 1'b0, 10'h000);
      chk("idle_starve_cnt", 32'(dut.starve_cnt), 32'h0);
    end

    // Reset during pending starvation, with a read in flight
    for (int c = 0; c < 3; c++) step(1'b1, 10'h000, 1'b1, 10'h078);
    pulse_reset();
    for (int c = 0; c < 6; c++) step(1'b1, 10'h000, 1'b1, 10'h078);

    // Random traffic, mostly contended, with rare resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 10'($urandom),
             1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'($urandom_range(0, 255) * 4));
      end
    end
    step(1'b0, 10'h000, 1'b0, 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
